// File: rtl/spectrum_pkg.sv
// Shared constants and enums for the spectrum RAM arbiter.
// Channel encodings, clear FSM states and slot kinds used by the top and the bench.
package spectrum_pkg;

    localparam int   BW_X = 9;
    localparam logic CH_R = 1'b0;
    localparam logic CH_L = 1'b1;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } clr_state_t;

    typedef enum logic [1:0] {
        SLOT_NONE,
        SLOT_READ,
        SLOT_CLEAR,
        SLOT_WRITE
    } slot_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with registered full/empty flags, zero-latency dout (head entry).
// Push while full and pop while empty are ignored; the caller tracks drops.
module sync_fifo #(
    parameter int width = 8,
    parameter int depth = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [width-1:0] din_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [width-1:0] dout_o
);
    localparam int AW = $clog2(depth);
    localparam int CW = AW + 1;

    logic [width-1:0] mem_q [depth];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, empty_q;
    logic             do_push, do_pop;

    assign do_push = push_i & ~full_q;
    assign do_pop  = pop_i & ~empty_q;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            // Flags are registered from next-state occupancy so they track this cycle's push/pop.
            full_q  <= (count_d == CW'(depth));
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge Clock) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign dout_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/spectrum_ram_arbiter.sv
// Single-port spectrum RAM arbiter: scanout reads win, then clear sweep, then buffered writes.
// RAM outputs registered (slot t -> RAM t+1), read data 3 cycles after RdReq; writes drop when FIFO full.
module spectrum_ram_arbiter
    import spectrum_pkg::*;
#(
    parameter int bw_x       = BW_X,
    parameter int bw_data    = 8,
    parameter int fifo_depth = 4
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               WrReq,
    input  logic               WrCh,
    input  logic [bw_x-1:0]    WrX,
    input  logic [bw_data-1:0] WrData,
    output logic               WrFull,
    output logic               Overflow,
    input  logic               RdReq,
    input  logic               RdCh,
    input  logic [bw_x-1:0]    RdX,
    output logic [bw_data-1:0] RdData,
    output logic               RdValid,
    input  logic               ClearReq,
    output logic               ClearBusy,
    output logic               RamCE,
    output logic               RamWE,
    output logic [bw_x:0]      RamAddr,
    output logic [bw_data-1:0] RamWData,
    input  logic [bw_data-1:0] RamRData
);
    localparam int AW = bw_x + 1;
    localparam int EW = 1 + bw_x + bw_data;

    logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [EW-1:0]      fifo_dout;

    clr_state_t         state_q, state_d;
    logic [AW-1:0]      clr_cnt_q, clr_cnt_d;
    slot_t              slot;

    logic               ram_ce_q, ram_ce_d;
    logic               ram_we_q, ram_we_d;
    logic [AW-1:0]      ram_addr_q, ram_addr_d;
    logic [bw_data-1:0] ram_wdata_q, ram_wdata_d;

    logic               overflow_q;
    logic [1:0]         rd_pipe_q;
    logic               rd_valid_q;
    logic [bw_data-1:0] rd_data_q;

    assign fifo_push = WrReq & ~fifo_full;

    sync_fifo #(
        .width (EW),
        .depth (fifo_depth)
    ) u_wr_fifo (
        .Clock   (Clock),
        .Reset   (Reset),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .din_i   ({WrCh, WrX, WrData}),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .dout_o  (fifo_dout)
    );

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        slot        = SLOT_NONE;
        fifo_pop    = 1'b0;
        ram_addr_d  = '0;
        ram_wdata_d = '0;

        if (RdReq) begin
            slot = SLOT_READ;
        end else if (state_q == ST_CLEAR) begin
            slot = SLOT_CLEAR;
        end else if (!fifo_empty) begin
            slot     = SLOT_WRITE;
            fifo_pop = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (ClearReq) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            ST_CLEAR: begin
                if (slot == SLOT_CLEAR) begin
                    clr_cnt_d = clr_cnt_q + AW'(1);
                    if (clr_cnt_q == '1) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        case (slot)
            SLOT_READ:  ram_addr_d = {RdCh, RdX};
            SLOT_CLEAR: ram_addr_d = clr_cnt_q;
            SLOT_WRITE: begin
                ram_addr_d  = fifo_dout[EW-1:bw_data];
                ram_wdata_d = fifo_dout[bw_data-1:0];
            end
            default: ram_addr_d = '0;
        endcase

        ram_ce_d = (slot != SLOT_NONE);
        ram_we_d = (slot == SLOT_CLEAR) || (slot == SLOT_WRITE);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ram_ce_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            overflow_q  <= 1'b0;
            rd_pipe_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            ram_ce_q    <= ram_ce_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            // A push into a full FIFO is lost even if the head pops this cycle.
            if (WrReq && fifo_full) overflow_q <= 1'b1;
            rd_pipe_q   <= {rd_pipe_q[0], RdReq};
            rd_valid_q  <= rd_pipe_q[1];
            if (rd_pipe_q[1]) rd_data_q <= RamRData;
        end
    end

    assign WrFull    = fifo_full;
    assign Overflow  = overflow_q;
    assign ClearBusy = (state_q == ST_CLEAR);
    assign RamCE     = ram_ce_q;
    assign RamWE     = ram_we_q;
    assign RamAddr   = ram_addr_q;
    assign RamWData  = ram_wdata_q;
    assign RdValid   = rd_valid_q;
    assign RdData    = rd_data_q;

endmodule

// File: tb/tb_spectrum_ram_arbiter.sv
// Randomized bench for spectrum_ram_arbiter against a queue/array reference model of the slot rules.
// A behavioural single-port RAM answers the DUT's RAM port.
module tb_spectrum_ram_arbiter;
    import spectrum_pkg::*;

    localparam int BWX   = BW_X;
    localparam int BWD   = 8;
    localparam int DEPTH = 4;
    localparam int NADDR = 1 << (BWX + 1);

    logic           Clock = 1'b0;
    logic           Reset = 1'b0;
    logic           WrReq = 1'b0, WrCh = 1'b0;
    logic [BWX-1:0] WrX = '0;
    logic [BWD-1:0] WrData = '0;
    logic           WrFull, Overflow;
    logic           RdReq = 1'b0, RdCh = 1'b0;
    logic [BWX-1:0] RdX = '0;
    logic [BWD-1:0] RdData;
    logic           RdValid;
    logic           ClearReq = 1'b0;
    logic           ClearBusy;
    logic           RamCE, RamWE;
    logic [BWX:0]   RamAddr;
    logic [BWD-1:0] RamWData;
    logic [BWD-1:0] RamRData;

    always #5 Clock = ~Clock;

    spectrum_ram_arbiter #(
        .bw_x       (BWX),
        .bw_data    (BWD),
        .fifo_depth (DEPTH)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .WrReq     (WrReq),
        .WrCh      (WrCh),
        .WrX       (WrX),
        .WrData    (WrData),
        .WrFull    (WrFull),
        .Overflow  (Overflow),
        .RdReq     (RdReq),
        .RdCh      (RdCh),
        .RdX       (RdX),
        .RdData    (RdData),
        .RdValid   (RdValid),
        .ClearReq  (ClearReq),
        .ClearBusy (ClearBusy),
        .RamCE     (RamCE),
        .RamWE     (RamWE),
        .RamAddr   (RamAddr),
        .RamWData  (RamWData),
        .RamRData  (RamRData)
    );

    logic [BWD-1:0] ram [NADDR];
    always @(posedge Clock) begin
        if (RamCE) begin
            if (RamWE) ram[RamAddr] <= RamWData;
            else       RamRData     <= ram[RamAddr];
        end
    end

    typedef struct packed {
        logic           ch;
        logic [BWX-1:0] x;
        logic [BWD-1:0] d;
    } wr_t;

    typedef struct {
        int             due;
        logic [BWD-1:0] d;
    } rd_t;

    wr_t            wq[$];
    rd_t            rdq[$];
    logic [BWD-1:0] gmem [NADDR];
    bit             m_clear = 1'b0;
    int             m_cnt = 0;
    bit             m_ovf = 1'b0;
    bit             e_ce = 1'b0, e_we = 1'b0;
    logic [BWX:0]   e_addr = '0;
    logic [BWD-1:0] e_wdata = '0;
    int             cyc = 0;
    int             checks = 0;
    int             errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0h expected %0h", tag, cyc, act, exp);
        end
    endtask

    task automatic check_all_zero(input string ph);
        check({ph, "_WrFull"},    WrFull,    0);
        check({ph, "_Overflow"},  Overflow,  0);
        check({ph, "_RdValid"},   RdValid,   0);
        check({ph, "_RdData"},    RdData,    0);
        check({ph, "_ClearBusy"}, ClearBusy, 0);
        check({ph, "_RamCE"},     RamCE,     0);
        check({ph, "_RamWE"},     RamWE,     0);
        check({ph, "_RamAddr"},   RamAddr,   0);
        check({ph, "_RamWData"},  RamWData,  0);
    endtask

    // One clock cycle: check this cycle's outputs, then apply inputs and advance the model.
    task automatic cycle(input bit rd, input bit rch, input logic [BWX-1:0] rx,
                         input bit wr, input bit wch, input logic [BWX-1:0] wx,
                         input logic [BWD-1:0] wd, input bit clr);
        bit           was_clear, full_now;
        logic [BWX:0] a;
        wr_t          e;
        @(negedge Clock);
        cyc++;
        check("WrFull",    WrFull,    (wq.size() == DEPTH));
        check("Overflow",  Overflow,  m_ovf);
        check("ClearBusy", ClearBusy, m_clear);
        check("RamCE",     RamCE,     e_ce);
        check("RamWE",     RamWE,     e_we);
        check("RamAddr",   RamAddr,   e_addr);
        check("RamWData",  RamWData,  e_wdata);
        if (rdq.size() > 0 && rdq[0].due == cyc) begin
            check("RdValid", RdValid, 1);
            check("RdData",  RdData,  rdq[0].d);
            void'(rdq.pop_front());
        end else begin
            check("RdValid", RdValid, 0);
        end

        RdReq = rd; RdCh = rch; RdX = rx;
        WrReq = wr; WrCh = wch; WrX = wx; WrData = wd;
        ClearReq = clr;

        was_clear = m_clear;
        full_now  = (wq.size() == DEPTH);
        e_ce = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
        if (rd) begin
            a = {rch, rx};
            e_ce = 1'b1; e_addr = a;
            rdq.push_back('{cyc + 3, gmem[a]});
        end else if (was_clear) begin
            e_ce = 1'b1; e_we = 1'b1; e_addr = m_cnt[BWX:0];
            gmem[m_cnt] = '0;
            m_cnt++;
            if (m_cnt == NADDR) m_clear = 1'b0;
        end else if (wq.size() > 0) begin
            e = wq.pop_front();
            a = {e.ch, e.x};
            e_ce = 1'b1; e_we = 1'b1; e_addr = a; e_wdata = e.d;
            gmem[a] = e.d;
        end
        if (wr) begin
            if (full_now) m_ovf = 1'b1;
            else          wq.push_back('{wch, wx, wd});
        end
        if (!was_clear && clr) begin
            m_clear = 1'b1;
            m_cnt   = 0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int busy;
        int n;
        logic [BWX-1:0] rx, wx;
        logic [BWD-1:0] wd;

        for (int i = 0; i < NADDR; i++) gmem[i] = '0;

        #2 Reset = 1'b1;
        #1 check_all_zero("rst");
        repeat (3) @(negedge Clock);
        Reset = 1'b0;

        // Clear sweep with a write pushed mid-clear; also gives the RAM known contents.
        busy = 0;
        for (int i = 0; i < 1100; i++) begin
            cycle(1'b0, 1'b0, '0, (i == 500), CH_L, 9'd7, 8'h55, (i == 0));
            busy += int'(ClearBusy);
        end
        check("clear_len", busy, 1024);

        // Single write then readback of (L, 5).
        cycle(1'b0, 1'b0, '0, 1'b1, CH_L, 9'd5, 8'h3A, 1'b0);
        idle(4);
        cycle(1'b1, CH_L, 9'd5, 1'b0, 1'b0, '0, '0, 1'b0);
        idle(4);

        // Ten reads starve three queued writes.
        for (int i = 0; i < 10; i++) begin
            rx = BWX'($urandom); wx = BWX'($urandom); wd = BWD'($urandom);
            cycle(1'b1, 1'($urandom), rx, (i < 3), 1'($urandom), wx, wd, 1'b0);
        end
        idle(6);

        // Five writes under continuous reads: fifth is dropped, Overflow sticks.
        for (int i = 0; i < 8; i++) begin
            rx = BWX'($urandom); wx = BWX'($urandom); wd = BWD'($urandom);
            cycle(1'b1, 1'($urandom), rx, (i < 5), 1'($urandom), wx, wd, 1'b0);
        end
        idle(6);
        check("ovf_sticky", Overflow, 1);

        // Clear interleaved with alternating reads.
        busy = 0;
        for (int i = 0; i < 2100; i++) begin
            rx = BWX'($urandom);
            cycle((i % 2 == 1), 1'($urandom), rx, 1'b0, 1'b0, '0, '0, (i == 0));
            busy += int'(ClearBusy);
        end
        check("clear_alt_len", busy, 2048);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rx = BWX'($urandom); wx = BWX'($urandom); wd = BWD'($urandom);
            cycle(($urandom_range(0, 99) < 55), 1'($urandom), rx,
                  ($urandom_range(0, 99) < 30), 1'($urandom), wx, wd,
                  ($urandom_range(0, 1499) == 0));
        end

        n = 0;
        while ((m_clear || wq.size() > 0 || rdq.size() > 0) && n < 5000) begin
            idle(1);
            n++;
        end

        // Reset in the middle of a clear sweep with writes queued.
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
        n = 0;
        while (m_cnt < 300 && n < 2000) begin
            cycle(1'b0, 1'b0, '0, (n < 2), CH_R, BWX'(n + 40), BWD'(n + 1), 1'b0);
            n++;
        end
        check("pre_rst_busy", ClearBusy, 1);
        WrReq = 1'b0; RdReq = 1'b0; ClearReq = 1'b0;
        #2 Reset = 1'b1;
        #1 check_all_zero("midclr_rst");
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        check("post_rst_WrFull",    WrFull,    0);
        check("post_rst_ClearBusy", ClearBusy, 0);
        wq.delete();
        rdq.delete();
        m_clear = 1'b0; m_cnt = 0; m_ovf = 1'b0;
        e_ce = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
        idle(6);

        // RAM contents after an aborted clear are whatever the RAM holds; resync and read back.
        for (int i = 0; i < NADDR; i++) gmem[i] = ram[i];
        for (int i = 0; i < 40; i++) begin
            rx = BWX'($urandom); wx = BWX'($urandom); wd = BWD'($urandom);
            cycle(($urandom_range(0, 1) == 1), 1'($urandom), rx,
                  ($urandom_range(0, 3) == 0), 1'($urandom), wx, wd, 1'b0);
        end
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
